// File: rtl/quad_dec_pkg.sv
// quad_dec_pkg
//   Shared definitions for the quadrature decoder: parameter defaults,
//   the controller state enum, and the x4 transition classifier.
//   No ports; imported by quad_filter and quad_decoder.
package quad_dec_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int FILT_CYCLES_DEF = 3;
  localparam int WRAP_MAX_DEF    = 10;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } dec_state_t;

  // Encoded so that the value equals the position difference mod 4.
  typedef enum logic [1:0] {
    MV_NONE = 2'd0,
    MV_UP   = 2'd1,
    MV_ERR  = 2'd2,
    MV_DOWN = 2'd3
  } move_t;

  // Position of {A,B} along the up cycle 00 -> 10 -> 11 -> 01 -> 00.
  function automatic logic [1:0] quad_pos(input logic [1:0] ab);
    logic [1:0] pos;
    case (ab)
      2'b00:   pos = 2'd0;
      2'b10:   pos = 2'd1;
      2'b11:   pos = 2'd2;
      default: pos = 2'd3;
    endcase
    return pos;
  endfunction

  // +1 step is up, -1 step is down, a two-position jump means both
  // channels moved at once and the direction is unknowable.
  function automatic move_t classify(input logic [1:0] prev_ab,
                                     input logic [1:0] cur_ab);
    logic [1:0] diff;
    diff = quad_pos(cur_ab) - quad_pos(prev_ab);
    return move_t'(diff);
  endfunction

endpackage

// File: rtl/quad_filter.sv
// quad_filter
//   One encoder channel: a SYNC_STAGES-deep synchronizer followed by a
//   persistence filter. The filtered level only follows the synchronized
//   level once the two have differed for FILT_CYCLES consecutive cycles.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high; zeroes synchronizer, filter, counter
//   load  - while high, filtered level is copied straight from the
//           synchronizer output (used during start-up)
//   din   - asynchronous channel input
//   sync  - synchronizer output
//   filt  - filtered level
module quad_filter
  import quad_dec_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILT_CYCLES = FILT_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic din,
  output logic sync,
  output logic filt
);

  logic [SYNC_STAGES-1:0] chain;
  logic [3:0]             miss;

  assign sync = chain[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
      miss  <= '0;
      filt  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      if (load) begin
        filt <= sync;
        miss <= '0;
      end else if (sync != filt) begin
        // The edge that sees the FILT_CYCLES-th mismatch accepts the level.
        if (miss == 4'(FILT_CYCLES - 1)) begin
          filt <= sync;
          miss <= '0;
        end else begin
          miss <= miss + 4'd1;
        end
      end else begin
        miss <= '0;
      end
    end
  end

endmodule

// File: rtl/quad_decoder.sv
// quad_decoder
//   x4 quadrature decoder with per-channel synchronizer and glitch filter,
//   a wrapping position count 0..WRAP_MAX, and registered event pulses.
// Ports:
//   clk       - rising-edge clock
//   reset     - synchronous, active-high
//   enc_a     - asynchronous channel A
//   enc_b     - asynchronous channel B
//   clr       - synchronous count clear (honoured in RUN)
//   count     - position count
//   step      - one-cycle pulse per accepted count change
//   dir       - direction of last accepted step (1 = up)
//   wrap      - one-cycle pulse when count wraps in either direction
//   err       - one-cycle pulse when both filtered channels change together
//   state_dbg - current controller state (INIT/RUN) for observation
module quad_decoder
  import quad_dec_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILT_CYCLES = FILT_CYCLES_DEF,
  parameter int WRAP_MAX    = WRAP_MAX_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enc_a,
  input  logic       enc_b,
  input  logic       clr,
  output logic [3:0] count,
  output logic       step,
  output logic       dir,
  output logic       wrap,
  output logic       err,
  output dec_state_t state_dbg
);

  localparam int INIT_LEN = SYNC_STAGES + FILT_CYCLES;

  dec_state_t state;
  logic [4:0] init_cnt;
  logic [1:0] ref_ab;
  logic       sync_a, sync_b, filt_a, filt_b;
  logic       load;
  move_t      mv;

  assign load      = (state == INIT);
  assign state_dbg = state;

  quad_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES)) u_filt_a (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .din   (enc_a),
    .sync  (sync_a),
    .filt  (filt_a)
  );

  quad_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES)) u_filt_b (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .din   (enc_b),
    .sync  (sync_b),
    .filt  (filt_b)
  );

  always_comb begin
    mv = classify(ref_ab, {filt_a, filt_b});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= INIT;
      init_cnt <= '0;
      ref_ab   <= 2'b00;
      count    <= '0;
      dir      <= 1'b1;
      step     <= 1'b0;
      wrap     <= 1'b0;
      err      <= 1'b0;
    end else begin
      step <= 1'b0;
      wrap <= 1'b0;
      err  <= 1'b0;
      case (state)
        INIT: begin
          // Filters are loading from the synchronizers in parallel, so the
          // reference tracks the same source and RUN starts with no delta.
          ref_ab <= {sync_a, sync_b};
          if (init_cnt == 5'(INIT_LEN - 1)) begin
            state <= RUN;
          end else begin
            init_cnt <= init_cnt + 5'd1;
          end
        end
        RUN: begin
          ref_ab <= {filt_a, filt_b};
          err    <= (mv == MV_ERR);
          if (clr) begin
            count <= '0;
          end else begin
            case (mv)
              MV_UP: begin
                step <= 1'b1;
                dir  <= 1'b1;
                if (count == 4'(WRAP_MAX)) begin
                  count <= '0;
                  wrap  <= 1'b1;
                end else begin
                  count <= count + 4'd1;
                end
              end
              MV_DOWN: begin
                step <= 1'b1;
                dir  <= 1'b0;
                if (count == 4'd0) begin
                  count <= 4'(WRAP_MAX);
                  wrap  <= 1'b1;
                end else begin
                  count <= count - 4'd1;
                end
              end
              default: ;
            endcase
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth per encoder channel, legal range 2..4.
REQ-002 Parameter FILT_CYCLES, default 3: consecutive cycles a synchronized level must differ before it is accepted, legal range 1..15.
REQ-003 Parameter WRAP_MAX, default 10: highest count value; the count range is 0..WRAP_MAX.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 enc_a  input  1  asynchronous quadrature channel A.
REQ-007 enc_b  input  1  asynchronous quadrature channel B.
REQ-008 clr  input  1  synchronous count clear, active-high.
REQ-009 count  output  4  position count, 0..WRAP_MAX.
REQ-010 step  output  1  one-cycle pulse on every accepted count change.
REQ-011 dir  output  1  direction of the last accepted step; 1 = up, 0 = down.
REQ-012 wrap  output  1  one-cycle pulse when count wraps (WRAP_MAX->0 or 0->WRAP_MAX).
REQ-013 err  output  1  one-cycle pulse when both filtered channels change in the same cycle.

Function
REQ-014 Each channel SHALL pass through SYNC_STAGES flops, then a glitch filter: a mismatch counter increments while sync != filtered, clears on match, and the filtered level takes the sync value when the mismatch persists FILT_CYCLES cycles.
REQ-015 Decoding SHALL be x4: the up sequence of {A,B} is 00->10->11->01->00; the reverse order is down.
REQ-016 A legal up transition SHALL increment count, pulse step, and set dir=1; a legal down transition SHALL decrement count, pulse step, and set dir=0.
REQ-017 Up at count==WRAP_MAX SHALL give count=0 with wrap=1; down at count==0 SHALL give count=WRAP_MAX with wrap=1.
REQ-018 A two-bit change in one cycle SHALL pulse err, leave count and dir unchanged, give no step, and adopt the new {A,B} as the reference state.
REQ-019 Latency: a level held stable on an input SHALL change count/step on clock edge SYNC_STAGES+FILT_CYCLES, counting the first sampling edge as edge 0 (edge 5 with defaults).
REQ-020 The FSM SHALL have the states INIT and RUN: INIT lasts SYNC_STAGES+FILT_CYCLES cycles after reset, loading filtered levels and the reference state directly from the synchronizers with no step/err/wrap; the FSM then enters RUN and stays there until reset.
REQ-021 clr in RUN SHALL force count=0 on the next edge, suppress step/wrap that cycle, keep dir, and still update the reference state; clr takes priority over a simultaneous step.
REQ-022 Input pulses shorter than FILT_CYCLES synchronized cycles SHALL produce no output activity.
REQ-023 step, wrap, and err SHALL be registered and never high for more than one consecutive cycle per event.

Reset
REQ-024 On reset, count=0, dir=1, step=wrap=err=0, the FSM SHALL enter INIT, and the synchronizers, filters, and mismatch counters SHALL be zeroed.
REQ-025 Reset asserted mid-operation SHALL take effect on the next edge, overriding clr and any pending transition.

Structure
REQ-026 A shared package quad_dec_pkg SHALL hold the state enum (INIT, RUN) and the localparam defaults for SYNC_STAGES, FILT_CYCLES, and WRAP_MAX.
REQ-027 A sub-module quad_filter (synchronizer plus glitch filter, one channel) SHALL be instantiated once per channel.

Verification
REQ-028 Reset, then hold A=B=0 for 10 cycles -> count=0, no step/err/wrap; hold A=B=1 through INIT -> no err after RUN.
REQ-029 Drive 12 up edges, each held 8 cycles, from count=0 -> count sequence 1..10,0,1; one wrap pulse at 10->0; dir=1.
REQ-030 From count=0, drive one down edge -> count=10, wrap=1, dir=0; then one up edge -> count=0, wrap=1.
REQ-031 A 2-cycle glitch on enc_a -> no step, count unchanged; a 3-cycle hold -> one step, 5 edges after the first sampling edge.
REQ-032 Flip A and B together (00->11) -> err=1 for 1 cycle, count unchanged; the next legal edge steps from 11.
REQ-033 With count=7, assert clr in the same cycle a step is accepted -> count=0, step=0; assert reset mid-sequence -> all outputs at their reset values on the next edge.
